// File: rtl/instr_queue_pkg.sv
// Shared types for the decode-to-dispatch instruction queue:
// the RVFI debug word and the Tomasulo control word.
package rv32i_types;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
  } rvfi_word;

endpackage

package tomasula_types;

  localparam int IQ_DEPTH = 8;

  typedef enum logic [2:0] {
    OP_ALU  = 3'd0,
    OP_IMM  = 3'd1,
    OP_LOAD = 3'd2,
    OP_STOR = 3'd3,
    OP_BR   = 3'd4,
    OP_JAL  = 3'd5,
    OP_JALR = 3'd6,
    OP_LUI  = 3'd7
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } ctl_word;

  typedef struct packed {
    ctl_word              ctrl;
    rv32i_types::rvfi_word rvfi;
  } iq_entry_t;

endpackage

// File: rtl/instr_queue.sv
// Circular queue between decode/IR and dispatch, flushed
// in one cycle on mispredict.
module instr_queue #(
  parameter int DEPTH = tomasula_types::IQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_iq,
  input  tomasula_types::ctl_word ctrl_in,
  input  rv32i_types::rvfi_word   rvfi_in,
  output logic                    iq_ack,
  input  logic                    deq_ready,
  output logic                    deq_valid,
  output tomasula_types::ctl_word deq_ctrl,
  output rv32i_types::rvfi_word   deq_rvfi,
  input  logic                    flush,
  output logic                    full,
  output logic                    empty,
  output logic [PTR_W:0]          count
);

  import tomasula_types::*;

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  iq_entry_t mem [DEPTH];

  logic [PTR_W:0]   head;
  logic [PTR_W:0]   tail;
  logic [PTR_W-1:0] head_idx;
  logic [PTR_W-1:0] tail_idx;
  logic             deq_fire;

  assign head_idx = head[PTR_W-1:0];
  assign tail_idx = tail[PTR_W-1:0];

  assign empty = (head == tail);
  assign full  = (head_idx == tail_idx) &&
                 (head[PTR_W] != tail[PTR_W]);
  assign count = tail - head;

  assign deq_valid = ~empty;
  assign deq_ctrl  = mem[head_idx].ctrl;
  assign deq_rvfi  = mem[head_idx].rvfi;

  // A full queue still accepts when the head leaves this edge.
  assign deq_fire = deq_valid & deq_ready & ~flush;
  assign iq_ack   = ld_iq & ~flush & ~rst &
                    (~full | deq_fire);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (iq_ack)
        tail <= tail + PTR_ONE;
      if (deq_fire)
        head <= head + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (iq_ack)
      mem[tail_idx] <= '{ctrl: ctrl_in, rvfi: rvfi_in};
  end

endmodule
